fetch_buffer: RTL
=================

# fetch_buffer

Dual-issue instruction queue between the IF1 fetch stage and decode. Accepts one fetch group per cycle (up to two 32-bit instructions plus PC, exception and bad-address information), splits it into per-instruction entries, and presents up to two oldest entries per cycle to decode. Decouples fetch from decode back-pressure and discards all contents on a pipeline flush.

## Interface
- DEPTH, 8: number of single-instruction entries; a power of two, ≥4.
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- flush  in  1  discard all entries. Has priority over push and pop in the same cycle.
- in_valid  in  1  a fetch group is offered.
- in_ready  out  1  a group can be accepted: free entries ≥ 2.
- in_pc  in  32  fetch group PC; bit 2 set means slot 0 is a filler (NOP).
- in_inst0 / in_inst1  in  32 each  instruction at in_pc[31:3]·000 / ·100.
- in_exception  in  7  fetch exception code; nonzero means faulting.
- in_excp_flag  in  2  exception qualifier, carried unchanged.
- in_badv  in  32  faulting address, carried unchanged.
- out_valid  out  2  bit0: slot0 entry valid; bit1: slot1 entry valid (bit1 implies bit0).
- out_pc0 / out_pc1  out  32 each  entry PCs.
- out_inst0 / out_inst1  out  32 each  entry instructions.
- out_exception0 / out_exception1  out  7 each
- out_excp_flag0 / out_excp_flag1  out  2 each
- out_badv0 / out_badv1  out  32 each
- out_accept  in  2  decode consumes slot0 (bit0) and slot1 (bit1). Legal values: 00, 01, 11. Bits are ignored where out_valid is clear.

## Operation
- Storage: DEPTH-entry circular array {pc, inst, exception, excp_flag, badv}, plus head pointer, tail pointer (log2 DEPTH bits, wrapping) and count (log2 DEPTH + 1 bits).
- Push fires when in_valid & in_ready & !flush. Entries written, in order:
  - in_pc[2]=0, in_exception=0: two entries {pc, inst0} and {pc+4, inst1}.
  - in_pc[2]=1, in_exception=0: one entry {pc, inst1}. The filler slot is dropped.
  - in_exception≠0: one entry {pc, inst=0, exception, excp_flag, badv}. The second slot is dropped, because a faulting group ends fetch until flush.
- Pop count = popcount(out_accept & out_valid). Head advances by that amount; count updates as count + pushed − popped. Simultaneous push and pop are allowed.
- Outputs read combinationally from head and head+1 (mod DEPTH):
  - out_valid[0] = count≥1.
  - out_valid[1] = count≥2 and entry(head).exception==0. An excepting entry is always issued alone in slot0.
  - When out_valid is clear, the corresponding data fields hold whatever the stale storage contains.
- Flush: head, tail and count go to 0 next cycle. Storage contents are not cleared.
- in_ready = (DEPTH − count) ≥ 2. It is computed from registered count only, with no pop-through path.
- Overflow and underflow are impossible by construction. Count never exceeds DEPTH.

## Timing
- Reset (async, rstn low): head=tail=count=0 and all storage entries zeroed. Therefore out_valid=00, all out_* data =0, in_ready=1.
- Reset deassertion mid-operation: state restarts empty. No partial group survives.
- Latency without bypass: a group pushed at edge N is visible on out_* in the cycle after edge N.
- Throughput: 2 instructions/cycle in each direction in steady state.
- Wrap-around: writes at tail=DEPTH−1 place the second entry at index 0.
- Full: count=DEPTH−1 or DEPTH gives in_ready=0. A pop in that cycle does not raise in_ready until the next cycle.
- Flush with in_valid=1 the same cycle: the group is dropped and the buffer is empty next cycle.

## Configuration
- FETCH_BUF_BYPASS_EN defined:
  - When count==0, in_valid=1 and !flush, the incoming group's entries drive out_* combinationally in the same cycle, with the same split and exception rules.
  - Accepted bypassed entries are not written. Unaccepted ones are written normally.
  - in_ready stays 1 when count==0.
- FETCH_BUF_BYPASS_EN not defined: no input-to-output combinational path. Minimum latency is one cycle.

## Test plan
- Reset then push pc=0x1c000000, inst0=0x02800000, inst1=0x02800401, out_accept=11 → next cycle out_valid=11, out_pc0=0x1c000000, out_pc1=0x1c000004. The cycle after, out_valid=00.
- Push pc=0x1c000104 (bit2 set), inst1=0x50000400 → single entry: out_valid=01, out_pc0=0x1c000104, out_inst0=0x50000400.
- Push non-faulting group at 0x1c000000, then group pc=0x1c000008 with in_exception=7'h08, badv=0x1c000008, out_accept=01 each cycle → entries drain in order. The excepting entry appears with out_valid=01 and out_exception0=0x08 even when count≥2.
- Hold out_accept=00 and push 4 groups (DEPTH=8) → in_ready drops to 0 after count reaches 8; a fifth in_valid is not accepted. Then accept 11 for 4 cycles → PCs emerge in order across the pointer wrap.
- With count=6, assert flush together with in_valid=1 → next cycle out_valid=00, in_ready=1. A new push then appears unaffected by stale data.
- Assert rstn low mid-stream with count=5 → out_valid=00 and in_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_buffer.sv
// Dual-issue fetch queue: splits fetch groups into single-instruction entries and issues up to two per cycle.
// Optional same-cycle input-to-output bypass when empty: define FETCH_BUF_BYPASS_EN.
module fetch_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst0,
  input  logic [31:0] in_inst1,
  input  logic [6:0]  in_exception,
  input  logic [1:0]  in_excp_flag,
  input  logic [31:0] in_badv,
  output logic [1:0]  out_valid,
  output logic [31:0] out_pc0,
  output logic [31:0] out_pc1,
  output logic [31:0] out_inst0,
  output logic [31:0] out_inst1,
  output logic [6:0]  out_exception0,
  output logic [6:0]  out_exception1,
  output logic [1:0]  out_excp_flag0,
  output logic [1:0]  out_excp_flag1,
  output logic [31:0] out_badv0,
  output logic [31:0] out_badv1,
  input  logic [1:0]  out_accept
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [6:0]  exc;
    logic [1:0]  flag;
    logic [31:0] badv;
  } entry_t;

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  entry_t [DEPTH-1:0] w_mem;

  logic [AW-1:0] w_head1;
  logic [AW-1:0] w_tail1;
  entry_t        w_st0;
  entry_t        w_st1;
  logic [1:0]    w_st_valid;

  entry_t        w_grp0;
  entry_t        w_grp1;
  logic [1:0]    w_grp_n;

  entry_t        w_out0;
  entry_t        w_out1;
  logic [1:0]    w_out_valid;

  logic          w_push;
  logic [1:0]    w_take;
  logic [1:0]    w_pop_n;
  logic [1:0]    w_head_adv;
  logic [1:0]    w_wr_n;
  entry_t        w_wr0;
  entry_t        w_wr1;

  // Split the incoming group; a fault or a filler slot 0 leaves a single entry.
  always_comb begin
    w_grp0      = '0;
    w_grp1      = '0;
    w_grp_n     = 2'd0;
    w_grp0.pc   = in_pc;
    w_grp0.flag = in_excp_flag;
    w_grp0.badv = in_badv;
    w_grp1.pc   = in_pc + 32'd4;
    w_grp1.flag = in_excp_flag;
    w_grp1.badv = in_badv;
    if (in_exception != 7'd0) begin
      w_grp0.exc  = in_exception;
      w_grp0.inst = 32'd0;
      w_grp_n     = 2'd1;
    end else if (in_pc[2]) begin
      w_grp0.inst = in_inst1;
      w_grp_n     = 2'd1;
    end else begin
      w_grp0.inst = in_inst0;
      w_grp1.inst = in_inst1;
      w_grp_n     = 2'd2;
    end
  end

  assign in_ready = (r_count <= CW'(DEPTH - 2));
  assign w_push   = in_valid && in_ready && !flush;

  assign w_head1 = r_head + AW'(1);
  assign w_tail1 = r_tail + AW'(1);
  assign w_st0   = w_mem[r_head];
  assign w_st1   = w_mem[w_head1];

  assign w_st_valid[0] = (r_count != '0);
  assign w_st_valid[1] = (r_count >= CW'(2)) && (w_st0.exc == 7'd0);

`ifdef FETCH_BUF_BYPASS_EN
  logic w_byp;
  assign w_byp = (r_count == '0) && in_valid && !flush;

  always_comb begin
    w_out0      = w_st0;
    w_out1      = w_st1;
    w_out_valid = w_st_valid;
    if (w_byp) begin
      w_out0      = w_grp0;
      w_out1      = w_grp1;
      w_out_valid = {(w_grp_n == 2'd2), 1'b1};
    end
  end
`else
  always_comb begin
    w_out0      = w_st0;
    w_out1      = w_st1;
    w_out_valid = w_st_valid;
  end
`endif

  assign w_take  = out_accept & w_out_valid;
  assign w_pop_n = {1'b0, w_take[0]} + {1'b0, w_take[1]};

  // Decide which entries land in storage; bypassed-and-accepted entries are skipped.
  always_comb begin
    w_wr0      = w_grp0;
    w_wr1      = w_grp1;
    w_wr_n     = w_push ? w_grp_n : 2'd0;
    w_head_adv = w_pop_n;
`ifdef FETCH_BUF_BYPASS_EN
    if (w_byp) begin
      w_head_adv = 2'd0;
      w_wr_n     = w_grp_n - w_pop_n;
      if (w_pop_n == 2'd1) begin
        w_wr0 = w_grp1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_head_adv);
      r_tail  <= r_tail + AW'(w_wr_n);
      r_count <= r_count + CW'(w_wr_n) - CW'(w_head_adv);
    end
  end

  // Per-entry storage; the second entry of a pair goes to tail+1, wrapping to 0.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
    entry_t r_ent;
    logic   w_we0;
    logic   w_we1;

    assign w_we0 = (w_wr_n != 2'd0) && (r_tail == AW'(gi));
    assign w_we1 = (w_wr_n == 2'd2) && (w_tail1 == AW'(gi));

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_ent <= '0;
      end else if (w_we0) begin
        r_ent <= w_wr0;
      end else if (w_we1) begin
        r_ent <= w_wr1;
      end
    end

    assign w_mem[gi] = r_ent;
  end

  assign out_valid      = w_out_valid;
  assign out_pc0        = w_out0.pc;
  assign out_pc1        = w_out1.pc;
  assign out_inst0      = w_out0.inst;
  assign out_inst1      = w_out1.inst;
  assign out_exception0 = w_out0.exc;
  assign out_exception1 = w_out1.exc;
  assign out_excp_flag0 = w_out0.flag;
  assign out_excp_flag1 = w_out1.flag;
  assign out_badv0      = w_out0.badv;
  assign out_badv1      = w_out1.badv;

endmodule
